// File: rtl/tour_move_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tour_pkg
//  Description : Shared types and constants for the knight-tour move
//                sequencer: FSM states, command opcodes, headings and
//                response bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package tour_pkg;

   // Sequencer states; explicit width keeps the encoding stable across tools
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VERT   = 3'd1,
      WAIT_V = 3'd2,
      HORZ   = 3'd3,
      WAIT_H = 3'd4
   } tour_state_t;

   localparam logic [3:0] OP_MOVE    = 4'h4;
   localparam logic [3:0] OP_FANFARE = 4'h5;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_DONE = 8'h5A;

endpackage
`default_nettype wire

// File: rtl/tour_move_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tour_move_sequencer_if
//  Description : Bundles the TourLogic, UART_wrapper and cmd_proc facing
//                signals of the move sequencer. slave = sequencer view,
//                master = surrounding-system view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tour_move_sequencer_if #(
   parameter int IDX_W = 5
);
   logic             start_tour;
   logic [7:0]       move;
   logic [IDX_W-1:0] mv_indx;
   logic [15:0]      cmd_UART;
   logic             cmd_rdy_UART;
   logic             clr_cmd_rdy_UART;
   logic [15:0]      cmd;
   logic             cmd_rdy;
   logic             clr_cmd_rdy;
   logic             send_resp;
   logic [7:0]       resp;
   logic             tour_active;

   modport slave (
      input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_active
   );

   modport master (
      output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_active
   );
endinterface
`default_nettype wire

// File: rtl/tour_move_sequencer_decode.sv
`default_nettype none
// ============================================================================
//  Module      : knight_move_decode
//  Description : Turns a one-hot knight move into its vertical leg
//                (plain move) and horizontal leg (move with fanfare).
//                With several bits set the lowest one wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module knight_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move,
   output logic [15:0] vert_cmd,
   output logic [15:0] horz_cmd,
   output logic        valid
);

   logic [2:0] sel;
   logic       north;
   logic       east;
   logic [3:0] dy_mag;
   logic [3:0] dx_mag;

   // Priority-select the lowest set bit, then map it to direction and distance
   always_comb begin
      sel    = 3'd0;
      north  = 1'b1;
      east   = 1'b1;
      dy_mag = 4'd2;
      dx_mag = 4'd1;
      valid  = |move;
      // scanning high to low lets the lowest set bit overwrite the others
      for (int i = 7; i >= 0; i--) begin
         if (move[i]) sel = 3'(i);
      end
      case (sel)
         3'd0: begin north = 1'b1; dy_mag = 4'd2; east = 1'b1; dx_mag = 4'd1; end
         3'd1: begin north = 1'b1; dy_mag = 4'd2; east = 1'b0; dx_mag = 4'd1; end
         3'd2: begin north = 1'b1; dy_mag = 4'd1; east = 1'b0; dx_mag = 4'd2; end
         3'd3: begin north = 1'b0; dy_mag = 4'd1; east = 1'b0; dx_mag = 4'd2; end
         3'd4: begin north = 1'b0; dy_mag = 4'd2; east = 1'b0; dx_mag = 4'd1; end
         3'd5: begin north = 1'b0; dy_mag = 4'd2; east = 1'b1; dx_mag = 4'd1; end
         3'd6: begin north = 1'b0; dy_mag = 4'd1; east = 1'b1; dx_mag = 4'd2; end
         default: begin north = 1'b1; dy_mag = 4'd1; east = 1'b1; dx_mag = 4'd2; end
      endcase
      vert_cmd = {OP_MOVE,    (north ? HDG_N : HDG_S), dy_mag};
      horz_cmd = {OP_FANFARE, (east  ? HDG_E : HDG_W), dx_mag};
   end

endmodule
`default_nettype wire

// File: rtl/tour_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tour_move_sequencer
//  Description : Walks the solved knight tour and issues two legs per move
//                to cmd_proc (vertical, then horizontal with fanfare).
//                Outside a tour, UART commands pass straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
module tour_move_sequencer
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = 5
)(
   input  logic                  clk,
   input  logic                  rst_n,
   tour_move_sequencer_if.slave  bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

   tour_state_t      state_q,       state_d;
   logic [IDX_W-1:0] mv_indx_q,     mv_indx_d;
   logic             tour_active_q, tour_active_d;
   logic [15:0]      cmd_q,         cmd_d;
   logic             cmd_rdy_q,     cmd_rdy_d;

   logic [15:0]      vert_cmd;
   logic [15:0]      horz_cmd;
   logic             move_valid;
   logic             is_idle;
   logic             is_last;

   knight_move_decode u_decode (
      .move     (bus.move),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd),
      .valid    (move_valid)
   );

   // Next-state logic; a leg is latched one cycle after entering VERT/HORZ
   // because the move for a new mv_indx only becomes visible then
   always_comb begin
      state_d       = state_q;
      mv_indx_d     = mv_indx_q;
      tour_active_d = tour_active_q;
      cmd_d         = cmd_q;
      cmd_rdy_d     = cmd_rdy_q;
      case (state_q)
         IDLE: begin
            if (bus.start_tour) begin
               state_d       = VERT;
               mv_indx_d     = '0;
               tour_active_d = 1'b1;
               cmd_rdy_d     = 1'b0;
            end
         end
         VERT: begin
            if (!cmd_rdy_q) begin
               if (!move_valid) begin
                  // no legal move from TourLogic: abandon the tour silently
                  state_d       = IDLE;
                  tour_active_d = 1'b0;
               end else begin
                  cmd_d     = vert_cmd;
                  cmd_rdy_d = 1'b1;
               end
            end else if (bus.clr_cmd_rdy) begin
               state_d   = WAIT_V;
               cmd_rdy_d = 1'b0;
            end
         end
         WAIT_V: begin
            if (bus.send_resp) state_d = HORZ;
         end
         HORZ: begin
            if (!cmd_rdy_q) begin
               cmd_d     = horz_cmd;
               cmd_rdy_d = 1'b1;
            end else if (bus.clr_cmd_rdy) begin
               state_d   = WAIT_H;
               cmd_rdy_d = 1'b0;
            end
         end
         WAIT_H: begin
            if (bus.send_resp) begin
               if (mv_indx_q == LAST_IDX) begin
                  state_d       = IDLE;
                  tour_active_d = 1'b0;
               end else begin
                  state_d   = VERT;
                  mv_indx_d = mv_indx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d       = IDLE;
            tour_active_d = 1'b0;
            cmd_rdy_d     = 1'b0;
         end
      endcase
   end

   // Output muxing: UART pass-through in IDLE, registered legs during a tour
   always_comb begin
      is_idle              = (state_q == IDLE);
      is_last              = (mv_indx_q == LAST_IDX);
      bus.cmd              = is_idle ? bus.cmd_UART     : cmd_q;
      bus.cmd_rdy          = is_idle ? bus.cmd_rdy_UART : cmd_rdy_q;
      bus.clr_cmd_rdy_UART = is_idle & bus.clr_cmd_rdy;
      bus.mv_indx          = mv_indx_q;
      bus.tour_active      = tour_active_q;
      // the final send_resp must already carry the done byte
      bus.resp             = (tour_active_q && !((state_q == WAIT_H) && is_last))
                             ? RESP_ACK : RESP_DONE;
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mv_indx_q     <= '0;
         tour_active_q <= 1'b0;
         cmd_q         <= 16'h0000;
         cmd_rdy_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         mv_indx_q     <= mv_indx_d;
         tour_active_q <= tour_active_d;
         cmd_q         <= cmd_d;
         cmd_rdy_q     <= cmd_rdy_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tour_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tour_move_sequencer
//  Description : Self-checking bench for tour_move_sequencer: UART
//                pass-through, decode vector table, full tour with a
//                cmd_proc model, UART blocking, mid-tour reset, zero move.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_move_sequencer;
   import tour_pkg::*;

   localparam int NUM_MOVES = 24;
   localparam int IDX_W     = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tour_move_sequencer_if #(.IDX_W(IDX_W)) bus();

   tour_move_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]  mv;
      logic [15:0] v;
      logic [15:0] h;
   } vec_t;

   vec_t        vecs[11];
   logic [7:0]  tour_moves[32];
   logic        ovr_en;
   logic [7:0]  move_ovr;
   logic [15:0] sb_q[$];

   int n_cmp  = 0;
   int n_err  = 0;
   int n_hs   = 0;
   int n_viol = 0;

   // TourLogic model: move depends combinationally on mv_indx
   assign bus.move = ovr_en ? move_ovr : tour_moves[bus.mv_indx];

   // Bus monitor sampled just before the next rising edge
   always @(negedge clk) begin
      #3;
      if (bus.tour_active && bus.cmd_rdy && bus.clr_cmd_rdy) n_hs++;
      if (bus.tour_active && (bus.clr_cmd_rdy_UART ||
          (bus.cmd_rdy && bus.cmd == bus.cmd_UART))) n_viol++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start_tour = 1'b1;
      step();
      bus.start_tour = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      sb_q.delete();
   endtask

   // cmd_proc model for one leg: wait for cmd_rdy, score it, accept, and
   // optionally report completion after checking the response byte
   task automatic do_leg(input string name, input int exp_idx,
                         input logic [7:0] exp_resp, input bit send);
      bit          got;
      logic [15:0] e;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         step();
         if (bus.cmd_rdy) got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got cmd_rdy=0 required cmd_rdy=1", name);
         return;
      end
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_sb: got cmd %h required none pending", name, bus.cmd);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_cmd"}, bus.cmd, e);
      end
      chk({name, "_idx"}, 16'(bus.mv_indx), 16'(exp_idx));
      bus.clr_cmd_rdy = 1'b1;
      step();
      bus.clr_cmd_rdy = 1'b0;
      chk({name, "_rdy_drop"}, 16'(bus.cmd_rdy), 16'h0);
      chk({name, "_resp"}, 16'(bus.resp), 16'(exp_resp));
      if (send) begin
         bus.send_resp = 1'b1;
         step();
         bus.send_resp = 1'b0;
      end
   endtask

   initial begin
      int hs0;
      int v0;
      rst_n            = 1'b0;
      bus.start_tour   = 1'b0;
      bus.cmd_UART     = 16'h0000;
      bus.cmd_rdy_UART = 1'b0;
      bus.clr_cmd_rdy  = 1'b0;
      bus.send_resp    = 1'b0;
      ovr_en           = 1'b0;
      move_ovr         = 8'h00;

      vecs[0]  = '{8'h01, 16'h4002, 16'h5BF1};
      vecs[1]  = '{8'h02, 16'h4002, 16'h53F1};
      vecs[2]  = '{8'h04, 16'h4001, 16'h53F2};
      vecs[3]  = '{8'h08, 16'h47F1, 16'h53F2};
      vecs[4]  = '{8'h10, 16'h47F2, 16'h53F1};
      vecs[5]  = '{8'h20, 16'h47F2, 16'h5BF1};
      vecs[6]  = '{8'h40, 16'h47F1, 16'h5BF2};
      vecs[7]  = '{8'h80, 16'h4001, 16'h5BF2};
      vecs[8]  = '{8'h0C, 16'h4001, 16'h53F2};
      vecs[9]  = '{8'hF0, 16'h47F2, 16'h53F1};
      vecs[10] = '{8'hFF, 16'h4002, 16'h5BF1};
      for (int i = 0; i < 32; i++)
         tour_moves[i] = (i < NUM_MOVES) ? 8'(1 << ((i * 3) % 8)) : 8'h00;

      // reset state
      repeat (3) step();
      chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'h0);
      rst_n = 1'b1;
      step();
      chk("rst_tour_active", 16'(bus.tour_active), 16'h0);
      chk("rst_mv_indx", 16'(bus.mv_indx), 16'h0);
      chk("rst_resp", 16'(bus.resp), 16'h005A);
      chk("rst_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'h0);

      // UART pass-through in IDLE
      bus.cmd_UART     = 16'h4002;
      bus.cmd_rdy_UART = 1'b1;
      #1;
      chk("pt_cmd", bus.cmd, 16'h4002);
      chk("pt_cmd_rdy", 16'(bus.cmd_rdy), 16'h1);
      bus.clr_cmd_rdy = 1'b1;
      #1;
      chk("pt_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'h1);
      step();
      bus.clr_cmd_rdy  = 1'b0;
      bus.cmd_rdy_UART = 1'b0;
      bus.cmd_UART     = 16'h1234;
      #1;
      chk("pt_clr_uart_low", 16'(bus.clr_cmd_rdy_UART), 16'h0);

      // decode vector table, one tour start per vector
      ovr_en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         move_ovr = vecs[i].mv;
         sb_q.push_back(vecs[i].v);
         sb_q.push_back(vecs[i].h);
         pulse_start();
         do_leg("vec_v", 0, RESP_ACK, 1'b1);
         do_leg("vec_h", 0, RESP_ACK, 1'b0);
         do_reset();
      end

      // all-zero move: abort without a command
      move_ovr = 8'h00;
      pulse_start();
      chk("zero_active_set", 16'(bus.tour_active), 16'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("zero_no_rdy", 16'(bus.cmd_rdy), 16'h0);
      end
      chk("zero_active_clr", 16'(bus.tour_active), 16'h0);
      chk("zero_resp", 16'(bus.resp), 16'h005A);
      ovr_en = 1'b0;

      // full tour; UART command appears at move 5, stray start at move 7
      hs0 = n_hs;
      v0  = n_viol;
      for (int i = 0; i < NUM_MOVES; i++) begin
         sb_q.push_back(vecs[(i * 3) % 8].v);
         sb_q.push_back(vecs[(i * 3) % 8].h);
      end
      pulse_start();
      for (int i = 0; i < NUM_MOVES; i++) begin
         if (i == 5) bus.cmd_rdy_UART = 1'b1;
         do_leg("tour_v", i, RESP_ACK, 1'b1);
         if (i == 7) pulse_start();
         do_leg("tour_h", i, (i == NUM_MOVES - 1) ? RESP_DONE : RESP_ACK, 1'b1);
      end
      chk("tour_active_end", 16'(bus.tour_active), 16'h0);
      chk("tour_handshakes", 16'(n_hs - hs0), 16'd48);
      chk("tour_uart_blocked", 16'(n_viol - v0), 16'd0);
      chk("tour_end_resp", 16'(bus.resp), 16'h005A);
      chk("uart_fwd_cmd", bus.cmd, 16'h1234);
      chk("uart_fwd_rdy", 16'(bus.cmd_rdy), 16'h1);
      bus.clr_cmd_rdy = 1'b1;
      #1;
      chk("uart_fwd_clr", 16'(bus.clr_cmd_rdy_UART), 16'h1);
      step();
      bus.clr_cmd_rdy  = 1'b0;
      bus.cmd_rdy_UART = 1'b0;

      // reset in WAIT_H of move 10
      for (int i = 0; i <= 10; i++) begin
         sb_q.push_back(vecs[(i * 3) % 8].v);
         sb_q.push_back(vecs[(i * 3) % 8].h);
      end
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         do_leg("mr_v", i, RESP_ACK, 1'b1);
         do_leg("mr_h", i, RESP_ACK, 1'b1);
      end
      do_leg("mr_v", 10, RESP_ACK, 1'b1);
      do_leg("mr_h", 10, RESP_ACK, 1'b0);
      do_reset();
      chk("mr_tour_active", 16'(bus.tour_active), 16'h0);
      chk("mr_mv_indx", 16'(bus.mv_indx), 16'h0);
      chk("mr_cmd_rdy", 16'(bus.cmd_rdy), 16'h0);
      chk("mr_resp", 16'(bus.resp), 16'h005A);
      repeat (3) step();
      chk("mr_stays_idle", 16'(bus.cmd_rdy), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
